// File: rtl/bus_defs.sv
// rtl/bus_defs.sv - shared bus protocol constants and responder state encoding
//
// Purpose: definitions shared by the responder and by any initiator that
//          speaks the same begin/end burst bus.
// Contents: DATA_WIDTH, ALIGN_BITS (byte-offset bits that must be zero),
//           BURST_WIDTH (width of burstSizeIn), bus_state_e (FSM states).
package bus_defs;

  localparam int DATA_WIDTH  = 32;
  localparam int ALIGN_BITS  = 2;
  localparam int BURST_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ_WAIT = 3'd2,
    ST_READ      = 3'd3,
    ST_ERROR     = 3'd4
  } bus_state_e;

endpackage

// File: rtl/bus_sram_responder_if.sv
// rtl/bus_sram_responder_if.sv - burst bus signal bundle with initiator/responder views
//
// Purpose: groups the shared address/data bus and its strobes.
// Signals: beginTransactionIn, endTransactionIn, readNotWriteIn, burstSizeIn,
//          addressDataIn, dataValidIn (initiator -> responder);
//          addressDataOut, dataValidOut, endTransactionOut, busErrorOut
//          (responder -> initiator).
// Modports: master (initiator side), slave (responder side).
interface bus_sram_responder_if;

  logic                             beginTransactionIn;
  logic                             endTransactionIn;
  logic                             readNotWriteIn;
  logic [bus_defs::BURST_WIDTH-1:0] burstSizeIn;
  logic [bus_defs::DATA_WIDTH-1:0]  addressDataIn;
  logic                             dataValidIn;
  logic [bus_defs::DATA_WIDTH-1:0]  addressDataOut;
  logic                             dataValidOut;
  logic                             endTransactionOut;
  logic                             busErrorOut;

  modport master (
    output beginTransactionIn, endTransactionIn, readNotWriteIn,
           burstSizeIn, addressDataIn, dataValidIn,
    input  addressDataOut, dataValidOut, endTransactionOut, busErrorOut
  );

  modport slave (
    input  beginTransactionIn, endTransactionIn, readNotWriteIn,
           burstSizeIn, addressDataIn, dataValidIn,
    output addressDataOut, dataValidOut, endTransactionOut, busErrorOut
  );

endinterface

// File: rtl/bus_sram_array.sv
// rtl/bus_sram_array.sv - single-clock SRAM, one write port, one registered read port
//
// Purpose: 2^ADDR_WIDTH x DATA_WIDTH storage; contents are never reset.
// Ports: clk_i; wr_en_i/wr_addr_i/wr_data_i (write port);
//        rd_en_i/rd_addr_i (read request), rd_data_o (data one cycle later,
//        zero in any cycle that follows a cycle without rd_en_i).
module bus_sram_array #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Clearing the read register when idle lets it drive a wired-OR bus directly.
  always_ff @(posedge clk_i) begin
    rd_data_q <= rd_en_i ? mem_q[rd_addr_i] : '0;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bus_sram_responder.sv
// rtl/bus_sram_responder.sv - SRAM-backed responder for the begin/end burst bus
//
// Purpose: claims bursts addressed to its window, writes/reads a local SRAM,
//          flags misaligned addresses with a one-cycle error/end strobe.
// Ports: clock, reset (synchronous, active-low);
//        bus (slave view of bus_sram_responder_if).
module bus_sram_responder
  import bus_defs::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int          ADDR_WIDTH   = 10
) (
  input logic                 clock,
  input logic                 reset,
  bus_sram_responder_if.slave bus
);

  localparam int TAG_LSB = ADDR_WIDTH + ALIGN_BITS;

  bus_state_e             state_q;
  logic [ADDR_WIDTH-1:0]  ptr_q;
  logic [BURST_WIDTH-1:0] cnt_q;
  logic                   dv_q;
  logic                   eot_q;
  logic                   err_q;

  logic                   claim;
  logic                   aligned;
  logic                   issue_rd;
  logic                   wr_en;
  logic [DATA_WIDTH-1:0]  rd_data;

  assign claim   = bus.beginTransactionIn &&
                   (bus.addressDataIn[31:TAG_LSB] == BASE_ADDRESS[31:TAG_LSB]);
  assign aligned = (bus.addressDataIn[ALIGN_BITS-1:0] == '0);

  // A read is issued one cycle before its word appears on the bus. In READ
  // cnt_q counts words still to issue; zero means the last word is on the bus.
  always_comb begin
    issue_rd = 1'b0;
    if (reset && !bus.endTransactionIn) begin
      if (state_q == ST_READ_WAIT) begin
        issue_rd = 1'b1;
      end else if (state_q == ST_READ && cnt_q != '0) begin
        issue_rd = 1'b1;
      end
    end
  end

  assign wr_en = reset && (state_q == ST_WRITE) && bus.dataValidIn;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
      eot_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      eot_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          dv_q <= 1'b0;
          if (claim) begin
            if (!aligned) begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
              eot_q   <= 1'b1;
            end else begin
              ptr_q   <= bus.addressDataIn[TAG_LSB-1:ALIGN_BITS];
              cnt_q   <= bus.burstSizeIn;
              state_q <= bus.readNotWriteIn ? ST_READ_WAIT : ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (bus.dataValidIn) begin
            ptr_q <= ptr_q + 1'b1;
            cnt_q <= cnt_q - 1'b1;
          end
          if (bus.endTransactionIn || (bus.dataValidIn && cnt_q == '0)) begin
            state_q <= ST_IDLE;
          end
        end
        ST_READ_WAIT: begin
          if (bus.endTransactionIn) begin
            dv_q    <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            ptr_q   <= ptr_q + 1'b1;
            dv_q    <= 1'b1;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          if (bus.endTransactionIn) begin
            dv_q    <= 1'b0;
            state_q <= ST_IDLE;
          end else if (cnt_q == '0) begin
            dv_q    <= 1'b0;
            eot_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            ptr_q <= ptr_q + 1'b1;
            cnt_q <= cnt_q - 1'b1;
            dv_q  <= 1'b1;
          end
        end
        ST_ERROR: begin
          dv_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          dv_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  bus_sram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk_i     (clock),
    .wr_en_i   (wr_en),
    .wr_addr_i (ptr_q),
    .wr_data_i (bus.addressDataIn),
    .rd_en_i   (issue_rd),
    .rd_addr_i (ptr_q),
    .rd_data_o (rd_data)
  );

  assign bus.addressDataOut    = rd_data;
  assign bus.dataValidOut      = dv_q;
  assign bus.endTransactionOut = eot_q;
  assign bus.busErrorOut       = err_q;

endmodule

// File: tb/tb_bus_sram_responder.sv
// tb/tb_bus_sram_responder.sv - directed and randomized bench for bus_sram_responder
module tb_bus_sram_responder;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] model_mem [1024];
  bit          model_vld [1024];
  logic [31:0] wq [$];

  bus_sram_responder_if bus_if ();

  bus_sram_responder #(
    .BASE_ADDRESS (32'h5000_0000),
    .ADDR_WIDTH   (10)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.beginTransactionIn = 1'b0;
    bus_if.endTransactionIn   = 1'b0;
    bus_if.readNotWriteIn     = 1'b0;
    bus_if.burstSizeIn        = 8'd0;
    bus_if.addressDataIn      = 32'd0;
    bus_if.dataValidIn        = 1'b0;
  endtask

  function automatic int widx(input logic [31:0] a, input int i);
    return (int'(a[11:2]) + i) % 1024;
  endfunction

  task automatic expect_out(input string tag, input logic [31:0] d, input logic dv,
                            input logic eot, input logic err, input bit chk_data);
    logic [2:0] obs;
    logic [2:0] exp;
    obs = {bus_if.dataValidOut, bus_if.endTransactionOut, bus_if.busErrorOut};
    exp = {dv, eot, err};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dv/eot/err observed=%b expected=%b", tag, obs, exp);
    end
    if (chk_data) begin
      checks++;
      assert (bus_if.addressDataOut === d) else begin
        errors++;
        $error("FAIL %s data observed=%h expected=%h", tag, bus_if.addressDataOut, d);
      end
    end
  endtask

  task automatic expect_quiet(input string tag);
    expect_out(tag, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Words come from wq when it holds data, else random. end_at: index of the
  // word carrying endTransactionIn (-1 for none).
  task automatic write_burst(input logic [31:0] addr, input int burst,
                             input int nwords, input int end_at);
    int          accepted;
    bit          open;
    logic [31:0] d;
    accepted = 0;
    open     = 1'b1;
    bus_if.beginTransactionIn = 1'b1;
    bus_if.readNotWriteIn     = 1'b0;
    bus_if.burstSizeIn        = burst[7:0];
    bus_if.addressDataIn      = addr;
    step();
    bus_if.beginTransactionIn = 1'b0;
    expect_quiet("write_begin");
    for (int i = 0; i < nwords; i++) begin
      d = (wq.size() > 0) ? wq.pop_front() : $urandom;
      bus_if.addressDataIn    = d;
      bus_if.dataValidIn      = 1'b1;
      bus_if.endTransactionIn = (i == end_at);
      if (open) begin
        model_mem[widx(addr, accepted)] = d;
        model_vld[widx(addr, accepted)] = 1'b1;
        accepted++;
        if (accepted == burst + 1 || i == end_at) open = 1'b0;
      end
      step();
      expect_quiet("write_data");
    end
    idle_inputs();
    step();
  endtask

  // abort_at / reset_at: word index during which endTransactionIn / reset=0
  // is applied (-1 for none).
  task automatic read_burst(input string tag, input logic [31:0] addr, input int burst,
                            input int abort_at, input int reset_at);
    int w;
    bus_if.beginTransactionIn = 1'b1;
    bus_if.readNotWriteIn     = 1'b1;
    bus_if.burstSizeIn        = burst[7:0];
    bus_if.addressDataIn      = addr;
    step();
    idle_inputs();
    expect_quiet({tag, "_wait"});
    for (int i = 0; i <= burst; i++) begin
      step();
      w = widx(addr, i);
      expect_out({tag, "_word"}, model_mem[w], 1'b1, 1'b0, 1'b0, model_vld[w]);
      if (i == abort_at) begin
        bus_if.endTransactionIn = 1'b1;
        step();
        bus_if.endTransactionIn = 1'b0;
        expect_quiet({tag, "_abort"});
        step();
        expect_quiet({tag, "_abort2"});
        return;
      end
      if (i == reset_at) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
        expect_quiet({tag, "_reset"});
        step();
        expect_quiet({tag, "_reset2"});
        return;
      end
    end
    step();
    expect_out({tag, "_end"}, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    expect_quiet({tag, "_after"});
  endtask

  initial begin
    logic [31:0] a;
    int          b;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) begin
      model_mem[i] = 32'd0;
      model_vld[i] = 1'b0;
    end
    idle_inputs();
    reset = 1'b0;
    repeat (3) step();
    expect_quiet("reset_state");
    reset = 1'b1;
    step();
    expect_quiet("post_reset");

    // Fixed four-word burst at word 4, then read it back.
    wq = '{32'h11, 32'h22, 32'h33, 32'h44};
    write_burst(32'h5000_0010, 3, 4, -1);
    read_burst("rd_fixed", 32'h5000_0010, 3, -1, -1);

    // Wrap from the last word to word 0, written and read.
    write_burst(32'h5000_0FFC, 1, 2, -1);
    read_burst("rd_wrap", 32'h5000_0FFC, 1, -1, -1);

    // Misaligned begin: one-cycle error+end, nothing written.
    bus_if.beginTransactionIn = 1'b1;
    bus_if.readNotWriteIn     = 1'b0;
    bus_if.burstSizeIn        = 8'd0;
    bus_if.addressDataIn      = 32'h5000_0002;
    step();
    bus_if.beginTransactionIn = 1'b0;
    bus_if.addressDataIn      = 32'hDEAD_BEEF;
    bus_if.dataValidIn        = 1'b1;
    expect_out("misaligned_err", 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    idle_inputs();
    expect_quiet("misaligned_after");
    step();
    read_burst("rd_after_err", 32'h5000_0000, 0, -1, -1);

    // Out-of-window begin with trailing data: bus stays silent, memory untouched.
    bus_if.beginTransactionIn = 1'b1;
    bus_if.readNotWriteIn     = 1'b0;
    bus_if.burstSizeIn        = 8'd3;
    bus_if.addressDataIn      = 32'h6000_0010;
    step();
    bus_if.beginTransactionIn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus_if.addressDataIn = $urandom;
      bus_if.dataValidIn   = (i < 4);
      expect_quiet("out_of_window");
      step();
    end
    idle_inputs();
    step();
    read_burst("rd_after_oow", 32'h5000_0010, 3, -1, -1);

    // Eight-word write cut short after the third word.
    write_burst(32'h5000_0200, 7, 8, -1);
    write_burst(32'h5000_0200, 7, 5, 2);
    read_burst("rd_short_wr", 32'h5000_0200, 7, -1, -1);

    // Excess words beyond the burst length are ignored.
    write_burst(32'h5000_0300, 1, 4, -1);
    read_burst("rd_excess", 32'h5000_0300, 3, -1, -1);

    // Read abort and reset in the middle of a read; memory survives both.
    read_burst("rd_abort", 32'h5000_0200, 7, 3, -1);
    read_burst("rd_reset", 32'h5000_0200, 7, -1, 2);
    read_burst("rd_reread", 32'h5000_0200, 7, -1, -1);

    // Randomized bursts, each read back in full.
    for (int n = 0; n < 6; n++) begin
      a = 32'h5000_0000 | ($urandom_range(0, 1023) << 2);
      b = $urandom_range(0, 15);
      write_burst(a, b, b + 1, -1);
      read_burst("rd_rand", a, b, -1, -1);
    end

    // Maximum burst length.
    a = 32'h5000_0000 | ($urandom_range(0, 1023) << 2);
    write_burst(a, 255, 256, -1);
    read_burst("rd_max", a, 255, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_sram_responder.md
BUS_SRAM_RESPONDER -- requirements
Module: bus_sram_responder

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h5000_0000, byte base of the responder window (aligned to window size).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, word-address width (window = 2^ADDR_WIDTH 32-bit words).
REQ-003 SHALL have ports, one per line:
 clock  in  1  single clock; all logic on rising edge.
 reset  in  1  synchronous, active-low (0 = reset).
 beginTransactionIn  in  1  initiator transaction start strobe.
 endTransactionIn  in  1  initiator end of write burst / read abort.
 readNotWriteIn  in  1  1 = read, 0 = write; sampled with beginTransactionIn.
 burstSizeIn  in  8  words in burst minus one; sampled with beginTransactionIn.
 addressDataIn  in  32  address on begin cycle, write data otherwise.
 dataValidIn  in  1  write data qualifier.
 addressDataOut  out  32  read data; 0 when not driving.
 dataValidOut  out  1  read data qualifier.
 endTransactionOut  out  1  read burst / error completion strobe.
 busErrorOut  out  1  error strobe.

Function
REQ-004 SHALL claim a transaction only when beginTransactionIn=1 and addressDataIn[31:ADDR_WIDTH+2] equals BASE_ADDRESS[31:ADDR_WIDTH+2]; otherwise outputs stay 0.
REQ-005 SHALL use FSM states IDLE, WRITE, READ_WAIT, READ, ERROR; beginTransactionIn outside IDLE is ignored.
REQ-006 SHALL, on a claimed begin cycle with addressDataIn[1:0]!=0, enter ERROR and assert busErrorOut and endTransactionOut together for exactly one cycle on the next cycle, then return to IDLE without touching memory.
REQ-007 SHALL load word pointer = addressDataIn[ADDR_WIDTH+1:2] and remaining count = burstSizeIn on a claimed aligned begin.
REQ-008 Write: in WRITE, each cycle with dataValidIn=1 writes addressDataIn to mem[pointer], increments pointer, decrements count.
REQ-009 Write SHALL end (go IDLE) on endTransactionIn=1 or after burstSizeIn+1 accepted words, whichever is first; dataValidIn on the endTransactionIn cycle is still written; excess words are ignored.
REQ-010 Read: begin at cycle T -> READ_WAIT at T+1 (synchronous RAM read), first dataValidOut=1 with mem[start] at T+2, one word per cycle, no gaps.
REQ-011 SHALL assert endTransactionOut for one cycle, the cycle after the last dataValidOut, with dataValidOut=0 and addressDataOut=0.
REQ-012 SHALL abort a read on endTransactionIn=1: outputs 0 from next cycle, IDLE, no endTransactionOut.
REQ-013 Pointer SHALL wrap modulo 2^ADDR_WIDTH (burst at last word continues at word 0); no error on wrap.
REQ-014 All outputs SHALL be registered and 0 whenever not actively signalling (wired-OR bus compatible).
REQ-015 burstSizeIn=0 SHALL yield a single-word transfer; 255 yields 256 words.

Reset
REQ-016 reset=0 at a rising edge SHALL force IDLE, all outputs 0, pointer/count 0 on the following cycle, including mid-burst.
REQ-017 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-018 State encoding and bus-protocol constants (address alignment bits, burst-size width) SHALL live in shared package/include bus_defs, reusable by initiators.
REQ-019 Storage SHALL be a sub-module bus_sram_array: 2^ADDR_WIDTH x 32, one write port, one synchronous read port, same clock.

Verification
REQ-020 Write burst: begin addr 32'h5000_0010, burstSize 3, data 11,22,33,44 -> mem[4..7]=11,22,33,44; read back same burst returns them T+2..T+5, endTransactionOut at T+6.
REQ-021 Wrap: read begin 32'h5000_0FFC, burstSize 1 -> data mem[1023], mem[0]; endTransactionOut after second word.
REQ-022 Misaligned 32'h5000_0002 -> busErrorOut=endTransactionOut=1 one cycle at T+1; memory unchanged.
REQ-023 Out-of-window 32'h6000_0000 begin -> all outputs 0 for 10 cycles.
REQ-024 Write burstSize 7 with endTransactionIn after 3rd word -> only 3 words written; next begin accepted normally.
REQ-025 reset=0 during 3rd word of 8-word read -> outputs 0 next cycle, no endTransactionOut; prior-written memory intact on re-read.
